// File: rtl/shifter_pkg.sv
// Shared definitions for the shift command sequencer: op codes, field widths,
// queue depth, FSM state encoding and the queued command payload.
package shifter_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned SHAMT_W = 2;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned RPT_W   = 3;
    localparam int unsigned Q_DEPTH = 4;
    localparam int unsigned PTR_W   = 2;
    localparam int unsigned LVL_W   = 3;

    localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
    localparam logic [OP_W-1:0] OP_LOAD = 3'b001;
    localparam logic [OP_W-1:0] OP_LSL  = 3'b010;
    localparam logic [OP_W-1:0] OP_LSR  = 3'b011;
    localparam logic [OP_W-1:0] OP_ASR  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // One queued command, 16 bits, op in the MSBs.
    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [SHAMT_W-1:0] shamt;
        logic [DATA_W-1:0]  data;
        logic [RPT_W-1:0]   rpt;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

    // True for ops that need SHIFT cycles; every other code behaves as NOP after LOAD.
    function automatic logic is_shift_op(input logic [OP_W-1:0] op_i);
        return (op_i == OP_LSL) || (op_i == OP_LSR) || (op_i == OP_ASR);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// 4-deep command FIFO with registered occupancy.
// Ports: clk, reset (sync, active-high), push/wr_data (ignored when full),
// pop (ignored when empty), head_c (combinational head entry),
// level (registered entry count 0..4), full_c.
module cmd_fifo
    import shifter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  cmd_t             wr_data,
    input  logic             pop,
    output cmd_t             head_c,
    output logic [LVL_W-1:0] level,
    output logic             full_c
);

    cmd_t             mem_q [Q_DEPTH];
    cmd_t             mem_d [Q_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             push_ok_c;
    logic             pop_ok_c;

    assign full_c    = (count_q == LVL_W'(Q_DEPTH));
    assign push_ok_c = push && !full_c;
    assign pop_ok_c  = pop && (count_q != LVL_W'(0));
    assign head_c    = mem_q[rd_ptr_q];
    assign level     = count_q;

    // Pointer, storage and occupancy update; pointers wrap naturally at 4.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_c) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push_ok_c, pop_ok_c})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Q_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/shift_cmd_seq.sv
// Shift command sequencer: queues {op,shamt,data,rpt} commands and replays each
// as LOAD, rpt+1 SHIFT cycles, then a DONE cycle, onto a shifter8 control bus.
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_op/in_shamt/
// in_data/in_rpt command input; op/shamt/d_out downstream shifter controls;
// busy, done (one-cycle pulse), level (queued count). in_ready and level are
// combinational views of the queue; all other outputs are registered.
module shift_cmd_seq
    import shifter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_op,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [RPT_W-1:0]   in_rpt,
    output logic [OP_W-1:0]    op,
    output logic [SHAMT_W-1:0] shamt,
    output logic [DATA_W-1:0]  d_out,
    output logic               busy,
    output logic               done,
    output logic [LVL_W-1:0]   level
);

    state_e             state_q, state_d;
    logic [OP_W-1:0]    cur_op_q, cur_op_d;
    logic [SHAMT_W-1:0] cur_shamt_q, cur_shamt_d;
    logic [RPT_W-1:0]   cnt_q, cnt_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [DATA_W-1:0]  d_out_q, d_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    cmd_t               in_cmd_c;
    cmd_t               head_c;
    logic               pop_c;
    logic               full_c;
    logic [LVL_W-1:0]   fifo_level;

    assign in_cmd_c = '{op: in_op, shamt: in_shamt, data: in_data, rpt: in_rpt};

    cmd_fifo u_cmd_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (in_valid),
        .wr_data (in_cmd_c),
        .pop     (pop_c),
        .head_c  (head_c),
        .level   (fifo_level),
        .full_c  (full_c)
    );

    assign in_ready = !full_c;
    assign level    = fifo_level;

    assign op    = op_q;
    assign shamt = shamt_q;
    assign d_out = d_out_q;
    assign busy  = busy_q;
    assign done  = done_q;

    // Next state and next registered outputs; outputs reflect the state being entered.
    always_comb begin
        state_d     = state_q;
        cur_op_d    = cur_op_q;
        cur_shamt_d = cur_shamt_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        shamt_d     = shamt_q;
        d_out_d     = d_out_q;
        done_d      = 1'b0;
        pop_c       = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (fifo_level != LVL_W'(0)) begin
                    // Pop the head and present it to the shifter as a LOAD.
                    pop_c       = 1'b1;
                    state_d     = ST_LOAD;
                    cur_op_d    = head_c.op;
                    cur_shamt_d = head_c.shamt;
                    cnt_d       = head_c.rpt;
                    op_d        = OP_LOAD;
                    shamt_d     = '0;
                    d_out_d     = head_c.data;
                end else begin
                    state_d = ST_IDLE;
                    op_d    = OP_NOP;
                    shamt_d = '0;
                end
            end
            ST_LOAD: begin
                if (is_shift_op(cur_op_q)) begin
                    state_d = ST_SHIFT;
                    op_d    = cur_op_q;
                    shamt_d = cur_shamt_q;
                end else begin
                    state_d = ST_DONE;
                    op_d    = OP_NOP;
                    shamt_d = '0;
                    done_d  = 1'b1;
                end
            end
            ST_SHIFT: begin
                // Counter starts at rpt, so the last shift cycle is the one at zero.
                if (cnt_q == RPT_W'(0)) begin
                    state_d = ST_DONE;
                    op_d    = OP_NOP;
                    shamt_d = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - RPT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                op_d    = OP_NOP;
                shamt_d = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cur_op_q    <= OP_NOP;
            cur_shamt_q <= '0;
            cnt_q       <= '0;
            op_q        <= OP_NOP;
            shamt_q     <= '0;
            d_out_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_op_q    <= cur_op_d;
            cur_shamt_q <= cur_shamt_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            shamt_q     <= shamt_d;
            d_out_q     <= d_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule
